cim_inst_issue: RTL and testbench

//  Instruction buffer/decoder directly upstream of CIM rw_control. Accepts 32-bit CIM instruction words
//  (op[31:27] s1[26:18] s2[17:9] d1[8:0], per CIM_INST_PKG), buffers them in a small FIFO, screens out NOP/

---
 rtl/cim_inst_issue.sv | 183 ++++++++++++++++++
 tb/tb_cim_inst_issue.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_inst_issue.sv
// Generic synchronous FIFO used as the instruction buffer.
// Latency: a word written at edge N is visible on rd_dat after edge N.
// Backpressure: caller must not push when full or pop when empty; clr empties it.
module cim_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wr_dat,
    output logic [W-1:0]               rd_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign rd_dat = mem[rd_ptr];
    assign full   = (level == LW'(DEPTH));
    assign empty  = (level == '0);

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// CIM instruction buffer/decoder feeding rw_control; drops NOP, illegal and out-of-range words.
// Latency: word pushed at edge N is presented on issue_* after edge N+1 when the path is idle.
// Backpressure: inst_ready falls when the FIFO is full or flushing; issue stalls on !issue_ready.
module cim_inst_issue #(
    parameter int FIFO_DEPTH = 4,
    parameter int OP_MAX     = 15,
    parameter int ADDR_LIMIT = 512,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          inst_valid,
    output logic                          inst_ready,
    input  logic [31:0]                   inst_data,
    output logic                          issue_valid,
    input  logic                          issue_ready,
    output logic [4:0]                    issue_op,
    output logic [8:0]                    issue_s1,
    output logic [8:0]                    issue_s2,
    output logic [8:0]                    issue_d1,
    output logic                          err_pulse,
    output logic [1:0]                    err_code,
    output logic [ERR_CNT_W-1:0]          err_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_BADADDR = 2'b10;

    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] head;
    logic        push;
    logic        pop;

    logic [4:0]  h_op;
    logic [8:0]  h_s1;
    logic [8:0]  h_s2;
    logic [8:0]  h_d1;
    logic        h_illegal;
    logic        h_badaddr;
    logic        h_nop;
    logic        h_ok;
    logic        head_act;
    logic        stage_free;
    logic        issue_load;
    logic        err_drop;

    assign inst_ready = rst_n && !fifo_full && !flush;
    assign push       = inst_valid && inst_ready;

    cim_fifo #(
        .W     (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (flush),
        .push   (push),
        .pop    (pop),
        .wr_dat (inst_data),
        .rd_dat (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    assign h_op = head[31:27];
    assign h_s1 = head[26:18];
    assign h_s2 = head[17:9];
    assign h_d1 = head[8:0];

    // Illegal opcode takes priority over a bad address on the same word.
    assign h_illegal = int'(h_op) > OP_MAX;
    assign h_badaddr = !h_illegal && ((int'(h_s1) >= ADDR_LIMIT) ||
                                      (int'(h_s2) >= ADDR_LIMIT) ||
                                      (int'(h_d1) >= ADDR_LIMIT));
    assign h_nop     = !h_illegal && !h_badaddr && (h_op == 5'd0);
    assign h_ok      = !h_illegal && !h_badaddr && !h_nop;

    assign head_act   = !fifo_empty && !flush;
    assign stage_free = !issue_valid || issue_ready;
    assign issue_load = head_act && h_ok && stage_free;
    assign err_drop   = head_act && (h_illegal || h_badaddr);
    assign pop        = head_act && (!h_ok || stage_free);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_valid <= 1'b0;
            issue_op    <= '0;
            issue_s1    <= '0;
            issue_s2    <= '0;
            issue_d1    <= '0;
        end else if (flush) begin
            issue_valid <= 1'b0;
        end else if (issue_load) begin
            issue_valid <= 1'b1;
            issue_op    <= h_op;
            issue_s1    <= h_s1;
            issue_s2    <= h_s2;
            issue_d1    <= h_d1;
        end else if (issue_ready) begin
            issue_valid <= 1'b0;
        end
    end

    // Error reporting lands one cycle after the offending word is popped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_pulse <= 1'b0;
            err_code  <= 2'b00;
            err_count <= '0;
        end else begin
            err_pulse <= err_drop;
            if (err_drop) begin
                err_code <= h_illegal ? ERR_ILLEGAL : ERR_BADADDR;
                if (err_count != {ERR_CNT_W{1'b1}}) begin
                    err_count <= err_count + 1'b1;
                end
            end
        end
    end

    assign busy = (fifo_level != '0) || issue_valid;
endmodule

// File: tb/tb_cim_inst_issue.sv
// Randomized scoreboard bench for cim_inst_issue; expected issues/errors are queued at push time.
module tb_cim_inst_issue;
    localparam int DEPTH = 4;
    localparam int OPM   = 15;
    localparam int AL    = 256;
    localparam int EW    = 3;
    localparam int EMAX  = (1 << EW) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  issue_op;
    logic [8:0]  issue_s1;
    logic [8:0]  issue_s2;
    logic [8:0]  issue_d1;
    logic        err_pulse;
    logic [1:0]  err_code;
    logic [EW-1:0] err_count;
    logic [$clog2(DEPTH):0] fifo_level;
    logic        busy;

    cim_inst_issue #(
        .FIFO_DEPTH (DEPTH),
        .OP_MAX     (OPM),
        .ADDR_LIMIT (AL),
        .ERR_CNT_W  (EW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_op    (issue_op),
        .issue_s1    (issue_s1),
        .issue_s2    (issue_s2),
        .issue_d1    (issue_d1),
        .err_pulse   (err_pulse),
        .err_code    (err_code),
        .err_count   (err_count),
        .fifo_level  (fifo_level),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_issue [$];
    logic [1:0]  exp_err   [$];
    int          m_err_cnt = 0;
    bit          p_hold = 0;
    logic [32:0] p_val;
    bit          rand_on = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference classification: 0 OK, 1 NOP, 2 illegal, 3 bad address.
    function automatic int classify(input logic [31:0] w);
        int op, a, b, c;
        op = int'(w >> 27);
        a  = int'((w >> 18) & 32'h1FF);
        b  = int'((w >> 9) & 32'h1FF);
        c  = int'(w & 32'h1FF);
        if (op > OPM) return 2;
        if (a >= AL || b >= AL || c >= AL) return 3;
        if (op == 0) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] mk(input int op, input int s1, input int s2, input int d1);
        return (32'(op) << 27) | (32'(s1) << 18) | (32'(s2) << 9) | 32'(d1);
    endfunction

    function automatic logic [31:0] rand_word();
        int r, op;
        int f [3];
        r = int'($urandom_range(0, 9));
        if (r == 0)      op = 0;
        else if (r == 1) op = int'($urandom_range(16, 31));
        else             op = int'($urandom_range(1, 15));
        for (int i = 0; i < 3; i++)
            f[i] = ($urandom_range(0, 11) == 0) ? int'($urandom_range(256, 511))
                                                : int'($urandom_range(0, 255));
        return mk(op, f[0], f[1], f[2]);
    endfunction

    // Monitor and reference model share one process so check-then-update order is fixed.
    always @(negedge clk) begin
        logic [31:0] w;
        logic [1:0]  c;
        int          k;
        if (err_pulse) begin
            if (exp_err.size() == 0) begin
                chk("err_unexpected", 1, 0);
            end else begin
                c = exp_err.pop_front();
                chk("err_code", 64'(err_code), 64'(c));
                if (m_err_cnt < EMAX) m_err_cnt++;
                chk("err_count", 64'(err_count), 64'(m_err_cnt));
            end
        end
        if (rst_n && issue_valid && issue_ready) begin
            if (exp_issue.size() == 0) begin
                chk("issue_unexpected", 1, 0);
            end else begin
                w = exp_issue.pop_front();
                chk("issue_fields", 64'({issue_op, issue_s1, issue_s2, issue_d1}), 64'(w));
            end
        end
        if (p_hold)
            chk("issue_hold", 64'({issue_valid, issue_op, issue_s1, issue_s2, issue_d1}), 64'(p_val));
        p_hold = rst_n && !flush && issue_valid && !issue_ready;
        p_val  = {1'b1, issue_op, issue_s1, issue_s2, issue_d1};
        if (fifo_level == DEPTH) chk("ready_when_full", 64'(inst_ready), 0);
        if (!rst_n || flush)     chk("ready_in_rst_flush", 64'(inst_ready), 0);
        chk("busy", 64'(busy), 64'((fifo_level != 0) || issue_valid));
        if (!rst_n) begin
            exp_issue.delete();
            exp_err.delete();
            m_err_cnt = 0;
        end else if (flush) begin
            exp_issue.delete();
            exp_err.delete();
        end else if (inst_valid && inst_ready) begin
            k = classify(inst_data);
            if (k == 0)      exp_issue.push_back(inst_data);
            else if (k == 2) exp_err.push_back(2'b01);
            else if (k == 3) exp_err.push_back(2'b10);
        end
    end

    // Entered and left at posedge+1.
    task automatic push_word(input logic [31:0] w, input int budget, output bit ok);
        inst_valid = 1'b1;
        inst_data  = w;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (inst_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        inst_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done;
        issue_ready = 1'b1;
        done = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1;
                break;
            end
        end
        if (!done) chk("drain_timeout", 0, 1);
        cycles(3);
    endtask

    initial begin
        bit ok;
        int acc;
        rst_n = 1'b0; flush = 1'b0; inst_valid = 1'b0; inst_data = '0; issue_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_issue_valid", 64'(issue_valid), 0);
        chk("rst_fields", 64'({issue_op, issue_s1, issue_s2, issue_d1}), 0);
        chk("rst_err", 64'({err_pulse, err_code, err_count}), 0);
        chk("rst_level", 64'(fifo_level), 0);
        chk("rst_inst_ready", 64'(inst_ready), 0);
        rst_n = 1'b1;
        cycles(1);

        // First-word latency: pushed at edge N, visible after edge N+1.
        issue_ready = 1'b1;
        inst_valid = 1'b1;
        inst_data  = 32'h0804_0602;
        @(posedge clk); #1;
        inst_valid = 1'b0;
        chk("lat_not_early", 64'(issue_valid), 0);
        @(posedge clk); #1;
        chk("lat_valid", 64'(issue_valid), 1);
        chk("lat_fields", 64'({issue_op, issue_s1, issue_s2, issue_d1}), 64'(mk(1, 1, 3, 2)));
        drain();

        // Backpressure: one word in the issue register, four in the FIFO, sixth refused.
        issue_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            push_word(mk(i + 1, i, i + 2, i + 3), 4, ok);
            if (ok) acc++;
        end
        chk("bp_accepted", 64'(acc), 5);
        chk("bp_level", 64'(fifo_level), 64'(DEPTH));
        chk("bp_ready_low", 64'(inst_ready), 0);
        drain();

        push_word(mk(31, 1, 1, 1), 10, ok);
        push_word(mk(3, 4, 5, 6), 10, ok);
        drain();
        chk("illegal_code", 64'(err_code), 1);
        chk("illegal_count", 64'(err_count), 1);

        push_word(mk(2, 5, 300, 7), 10, ok);
        push_word(mk(0, 1, 1, 1), 10, ok);
        drain();
        chk("badaddr_code", 64'(err_code), 2);
        chk("nop_silent_count", 64'(err_count), 2);

        // Flush with words buffered, issue pending and a push offered.
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(mk(4, i, i, i), 4, ok);
        chk("pre_flush_valid", 64'(issue_valid), 1);
        flush = 1'b1; inst_valid = 1'b1; inst_data = mk(5, 1, 2, 3);
        @(posedge clk); #1;
        flush = 1'b0; inst_valid = 1'b0;
        chk("flush_level", 64'(fifo_level), 0);
        chk("flush_valid", 64'(issue_valid), 0);
        issue_ready = 1'b1;
        cycles(5);
        chk("flush_quiet", 64'(issue_valid), 0);

        for (int i = 0; i < 10; i++) push_word(mk(20, i, i, i), 10, ok);
        drain();
        chk("sat_count", 64'(err_count), 64'(EMAX));

        // Randomized traffic with random backpressure and occasional flushes.
        rand_on = 1;
        fork
            begin
                while (rand_on) begin
                    @(posedge clk); #1;
                    issue_ready = ($urandom_range(0, 3) != 0);
                    flush       = ($urandom_range(0, 59) == 0);
                end
                flush = 1'b0;
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    push_word(rand_word(), 50, ok);
                    if (!ok) chk("push_timeout", 0, 1);
                    if ($urandom_range(0, 3) == 0) cycles(int'($urandom_range(1, 3)));
                end
                rand_on = 0;
            end
        join
        @(posedge clk); #1;
        flush = 1'b0;
        drain();

        // Reset in the middle of traffic discards everything in flight.
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word(mk(6, i, 2, 9), 4, ok);
        rst_n = 1'b0;
        cycles(2);
        chk("mid_rst_state", 64'({issue_valid, fifo_level, err_pulse, err_code, err_count}), 0);
        rst_n = 1'b1;
        issue_ready = 1'b1;
        cycles(4);
        chk("mid_rst_quiet", 64'(issue_valid), 0);
        for (int i = 0; i < 40; i++) push_word(rand_word(), 50, ok);
        drain();

        chk("leftover_issues", 64'(exp_issue.size()), 0);
        chk("leftover_errors", 64'(exp_err.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
